// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch
//   Edge-triggered two-entry skid buffer used as an inter-stage pipeline
//   register. It uses a valid/ready handshake on both sides. in_ready is
//   registered, so there is no combinational path from out_ready to in_ready.
//
// Parameters
//   WIDTH  : payload width in bits
//   BUBBLE : value driven on out_data whenever out_valid is 0
//
// Ports
//   clock     in   1      rising-edge clock
//   reset     in   1      synchronous, active-high
//   flush     in   1      synchronous; discards all held entries
//   in_data   in   WIDTH  upstream payload
//   in_valid  in   1      upstream offers in_data
//   in_ready  out  1      an entry can be accepted this cycle (registered)
//   out_data  out  WIDTH  head entry, or BUBBLE when empty (registered)
//   out_valid out  1      out_data holds a valid entry (registered)
//   out_ready in   1      downstream consumes the head this cycle
//   count     out  2      entries held: 0, 1 or 2 (registered)
module pipe_skid_latch #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic accept;
    logic release_h;

    assign accept    = in_valid & in_ready_q;
    assign release_h = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            // A release in this cycle is already complete downstream; any
            // beat accepted in this cycle is dropped.
            state_d = EMPTY;
            head_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && release_h) begin
                        head_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (release_h) begin
                        head_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (release_h) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = BUBBLE;
                end
            endcase
        end

        // Handshake flags are derived from the next state so they can be registered.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;
    assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    logic        flush8;
    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [1:0]  count8;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    pipe_skid_latch dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    pipe_skid_latch #(
        .WIDTH (8),
        .BUBBLE(8'hFF)
    ) dut8 (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush8),
        .in_data  (in_data8),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .out_data (out_data8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .count    (count8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".out_data"},  out_data,           d);
        chk({tag, ".count"},     {30'd0, count},     {30'd0, c});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA5555;
        flush8 = 1'b0; in_valid8 = 1'b1; in_data8 = 8'h55; out_ready8 = 1'b0;

        // 1 reset held two cycles with an offer on the input
        step(); step();
        chk_all("reset", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("reset8.out_data", {24'd0, out_data8}, 32'h0000_00FF);
        reset = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        step();
        chk_all("post_reset", 1'b0, 32'h0, 2'd0, 1'b1);

        // 2 back-to-back stream with out_ready high
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h1; step(); chk_all("stream1", 1'b1, 32'h1, 2'd1, 1'b1);
        in_data = 32'h2; step(); chk_all("stream2", 1'b1, 32'h2, 2'd1, 1'b1);
        in_data = 32'h3; step(); chk_all("stream3", 1'b1, 32'h3, 2'd1, 1'b1);
        in_valid = 1'b0; step(); chk_all("stream_drain", 1'b0, 32'h0, 2'd0, 1'b1);

        // 3 back-pressure into FULL, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h10; step(); chk_all("bp_one", 1'b1, 32'h10, 2'd1, 1'b1);
        in_data = 32'h11; step(); chk_all("bp_full", 1'b1, 32'h10, 2'd2, 1'b0);
        in_data = 32'h12; step(); chk_all("bp_hold", 1'b1, 32'h10, 2'd2, 1'b0);
        out_ready = 1'b1;
        step(); chk_all("bp_drain11", 1'b1, 32'h11, 2'd1, 1'b1);
        step(); chk_all("bp_drain12", 1'b1, 32'h12, 2'd1, 1'b1);
        in_valid = 1'b0;
        step(); chk_all("bp_empty", 1'b0, 32'h0, 2'd0, 1'b1);

        // 4 flush while FULL drops held entries and the offered beat
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h40; step();
        in_data = 32'h41; step(); chk_all("fl_full", 1'b1, 32'h40, 2'd2, 1'b0);
        flush = 1'b1; in_data = 32'h5;
        step(); chk_all("fl_flushed", 1'b0, 32'h0, 2'd0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        step(); chk_all("fl_dropped", 1'b0, 32'h0, 2'd0, 1'b1);
        in_valid = 1'b1; in_data = 32'h20;
        step(); chk_all("fl_after", 1'b1, 32'h20, 2'd1, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); chk_all("fl_drain", 1'b0, 32'h0, 2'd0, 1'b1);
        flush = 1'b1;
        step(); chk_all("fl_empty", 1'b0, 32'h0, 2'd0, 1'b1);
        flush = 1'b0;

        // 5 ONE with simultaneous accept and release
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h30;
        step(); chk_all("ar_head", 1'b1, 32'h30, 2'd1, 1'b1);
        out_ready = 1'b1; in_data = 32'h31;
        step(); chk_all("ar_swap", 1'b1, 32'h31, 2'd1, 1'b1);
        in_valid = 1'b0;
        step(); chk_all("ar_drain", 1'b0, 32'h0, 2'd0, 1'b1);

        // 6 narrow instance with a non-zero bubble
        chk("p8_idle", {24'd0, out_data8}, 32'h0000_00FF);
        in_valid8 = 1'b1; in_data8 = 8'h00;
        step();
        chk("p8_data",  {24'd0, out_data8},  32'h0000_0000);
        chk("p8_valid", {31'd0, out_valid8}, 32'h1);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        chk("p8_bubble", {24'd0, out_data8},  32'h0000_00FF);
        chk("p8_empty",  {31'd0, out_valid8}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
